ones_serializer: RTL and testbench

Parallel-to-serial stage that sits directly upstream of `ones_counter` and drives its 1-bit `data` input. It accepts WIDTH-bit words over a valid/ready handshake, shifts each word out LSB-first one bit per clock, and reports the number of ones in each completed word. Software and the bench can then cross-check the downstream counter's total against `word_ones`.

---
 rtl/ones_serializer.sv | 161 ++++++++++++++++
 tb/tb_ones_serializer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_serializer.sv
// ones_serializer: parallel-to-serial stage feeding ones_counter.
// Takes WIDTH-bit words over valid/ready and shifts them out LSB-first,
// one bit per clock, and reports the popcount of each completed word.
// GAP idle cycles can follow every word.
// Optional feature macro: ONES_SER_PARITY_EN appends an even-parity bit
// (XOR of the word) after bit WIDTH-1.
module ones_serializer #(
   parameter int WIDTH = 8,
   parameter int GAP   = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         data,
   output logic                         data_valid,
   output logic                         last,
   output logic [$clog2(WIDTH+1)-1:0]   word_ones,
   output logic                         busy
);

   localparam int CW = $clog2(WIDTH+1);
`ifdef ONES_SER_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int             BW        = $clog2(NBITS);
   localparam logic [BW-1:0]  LAST_IDX  = BW'(NBITS-1);
   localparam logic [3:0]     GAP_LOAD  = 4'(GAP);
   localparam bit             GAP_ZERO  = (GAP == 0);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   state_t            r_state;
   logic [NBITS-1:0]  r_shreg;
   logic [BW-1:0]     r_bitcnt;
   logic [CW-1:0]     r_shadow;
   logic [CW-1:0]     r_word_ones;
   logic [3:0]        r_gapcnt;
   logic              r_data;
   logic              r_data_valid;
   logic              r_last;
   logic              r_busy;

   state_t            w_state_next;
   logic [NBITS-1:0]  w_shreg_next;
   logic [BW-1:0]     w_bitcnt_next;
   logic [CW-1:0]     w_shadow_next;
   logic [CW-1:0]     w_word_ones_next;
   logic [3:0]        w_gapcnt_next;
   logic [NBITS-1:0]  w_load;
   logic [CW-1:0]     w_popcnt;
   logic              w_in_ready;
   logic              w_xfer;

   // Word as it enters the shift register (parity bit on top when enabled).
`ifdef ONES_SER_PARITY_EN
   assign w_load = {^in_data, in_data};
`else
   assign w_load = in_data;
`endif

   // Ready is a pure decode of registered state: idle, or the final bit when
   // no gap is configured so the next word can follow with no bubble.
   assign w_in_ready = (r_state == ST_IDLE) ||
                       (GAP_ZERO && (r_state == ST_SHIFT) && r_last);
   assign w_xfer     = in_valid && w_in_ready;

   // Ones count of the incoming word, captured into the shadow at transfer.
   always_comb begin
      w_popcnt = '0;
      for (int k = 0; k < WIDTH; k++) begin
         w_popcnt = w_popcnt + CW'(in_data[k]);
      end
   end

   // Next-state logic for the IDLE/SHIFT/GAP sequencer and its datapath.
   always_comb begin
      w_state_next     = r_state;
      w_shreg_next     = r_shreg;
      w_bitcnt_next    = r_bitcnt;
      w_shadow_next    = r_shadow;
      w_word_ones_next = r_word_ones;
      w_gapcnt_next    = r_gapcnt;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer) begin
               w_state_next  = ST_SHIFT;
               w_shreg_next  = w_load;
               w_shadow_next = w_popcnt;
               w_bitcnt_next = '0;
            end
         end
         ST_SHIFT: begin
            w_shreg_next  = r_shreg >> 1;
            w_bitcnt_next = r_bitcnt + BW'(1);
            if (r_bitcnt == LAST_IDX) begin
               w_word_ones_next = r_shadow;
               if (!GAP_ZERO) begin
                  w_state_next  = ST_GAP;
                  w_gapcnt_next = GAP_LOAD;
               end else if (w_xfer) begin
                  w_state_next  = ST_SHIFT;
                  w_shreg_next  = w_load;
                  w_shadow_next = w_popcnt;
                  w_bitcnt_next = '0;
               end else begin
                  w_state_next  = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            w_gapcnt_next = r_gapcnt - 4'd1;
            if (r_gapcnt <= 4'd1) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs (derived from next-state values
   // so that every output is a flop).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_shreg      <= '0;
         r_bitcnt     <= '0;
         r_shadow     <= '0;
         r_word_ones  <= '0;
         r_gapcnt     <= '0;
         r_data       <= 1'b0;
         r_data_valid <= 1'b0;
         r_last       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_shreg      <= w_shreg_next;
         r_bitcnt     <= w_bitcnt_next;
         r_shadow     <= w_shadow_next;
         r_word_ones  <= w_word_ones_next;
         r_gapcnt     <= w_gapcnt_next;
         r_data       <= (w_state_next == ST_SHIFT) && w_shreg_next[0];
         r_data_valid <= (w_state_next == ST_SHIFT);
         r_last       <= (w_state_next == ST_SHIFT) && (w_bitcnt_next == LAST_IDX);
         r_busy       <= (w_state_next != ST_IDLE);
      end
   end

   assign in_ready   = w_in_ready;
   assign data       = r_data;
   assign data_valid = r_data_valid;
   assign last       = r_last;
   assign word_ones  = r_word_ones;
   assign busy       = r_busy;

endmodule

// File: tb/tb_ones_serializer.sv
// Directed bench for ones_serializer: one DUT with GAP=0, one with GAP=2.
// A simple downstream ones counter is modelled for each DUT.
module tb_ones_serializer;

`ifdef ONES_SER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB = 8 + PAR;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d0_in_data, d2_in_data;
   logic       d0_in_valid, d2_in_valid;
   logic       d0_in_ready, d2_in_ready;
   logic       d0_data, d2_data;
   logic       d0_dv, d2_dv;
   logic       d0_last, d2_last;
   logic [3:0] d0_wo, d2_wo;
   logic       d0_busy, d2_busy;

   int total = 0;
   int bad   = 0;
   int cnt0  = 0;
   int cnt2  = 0;

   always #5 clk = ~clk;

   ones_serializer #(.WIDTH(8), .GAP(0)) u_dut0 (
      .clk(clk), .reset(rst), .in_data(d0_in_data), .in_valid(d0_in_valid),
      .in_ready(d0_in_ready), .data(d0_data), .data_valid(d0_dv),
      .last(d0_last), .word_ones(d0_wo), .busy(d0_busy));

   ones_serializer #(.WIDTH(8), .GAP(2)) u_dut2 (
      .clk(clk), .reset(rst), .in_data(d2_in_data), .in_valid(d2_in_valid),
      .in_ready(d2_in_ready), .data(d2_data), .data_valid(d2_dv),
      .last(d2_last), .word_ones(d2_wo), .busy(d2_busy));

   // Downstream ones counters: count qualified one bits at each rising edge.
   always @(posedge clk) begin
      if (d0_dv && d0_data) cnt0 <= cnt0 + 1;
      if (d2_dv && d2_data) cnt2 <= cnt2 + 1;
   end

   function automatic logic exp_bit(input logic [7:0] w, input int j);
      return (j < 8) ? w[j] : ^w;
   endfunction

   function automatic int exp_ones(input logic [7:0] w);
      int e = 0;
      for (int j = 0; j < NB; j++) e += int'(exp_bit(w, j));
      return e;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      d0_in_valid = 1'b0; d0_in_data = 8'h00;
      d2_in_valid = 1'b0; d2_in_data = 8'h00;
      #1 rst = 1'b1;
      #1;
      total++;
      if ({d0_data, d0_dv, d0_last, d0_busy, d0_in_ready, d0_wo} !== 9'b0000_1_0000) begin
         bad++;
         $display("FAIL reset_outputs got data=%0b dv=%0b last=%0b busy=%0b rdy=%0b wo=%0d want 0,0,0,0,1,0",
                  d0_data, d0_dv, d0_last, d0_busy, d0_in_ready, d0_wo);
      end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      total++;
      if (d0_in_ready !== 1'b1 || d0_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got rdy=%0b busy=%0b want 1,0", d0_in_ready, d0_busy);
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      int base;
      d0_in_data = 8'hA5; d0_in_valid = 1'b1;
      base = cnt0;
      @(negedge clk);
      d0_in_valid = 1'b0; d0_in_data = 8'h3C;  // must be ignored
      for (int i = 0; i < NB; i++) begin
         total++;
         if (d0_dv !== 1'b1 || d0_data !== exp_bit(8'hA5, i) || d0_last !== (i == NB-1)
             || d0_busy !== 1'b1 || d0_in_ready !== (i == NB-1)) begin
            bad++;
            $display("FAIL single_bit[%0d] got dv=%0b data=%0b last=%0b busy=%0b rdy=%0b want 1,%0b,%0b,1,%0b",
                     i, d0_dv, d0_data, d0_last, d0_busy, d0_in_ready,
                     exp_bit(8'hA5, i), (i == NB-1), (i == NB-1));
         end
         @(negedge clk);
      end
      total++;
      if (d0_wo !== 4'd4 || d0_dv !== 1'b0 || d0_data !== 1'b0 || d0_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL single_done got wo=%0d dv=%0b data=%0b rdy=%0b want 4,0,0,1",
                  d0_wo, d0_dv, d0_data, d0_in_ready);
      end
      total++;
      if (cnt0 - base !== exp_ones(8'hA5)) begin
         bad++;
         $display("FAIL single_count got=%0d want=%0d", cnt0 - base, exp_ones(8'hA5));
      end
      $display("test_single A5 done");
   endtask

   task automatic test_reset_midword();
      int base;
      d0_in_data = 8'hFF; d0_in_valid = 1'b1;
      base = cnt0;
      @(negedge clk);
      d0_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      total++;
      if (d0_dv !== 1'b1 || d0_data !== 1'b1) begin
         bad++;
         $display("FAIL midword_bit3 got dv=%0b data=%0b want 1,1", d0_dv, d0_data);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({d0_data, d0_dv, d0_last, d0_busy, d0_in_ready, d0_wo} !== 9'b0000_1_0000) begin
         bad++;
         $display("FAIL midword_reset got data=%0b dv=%0b last=%0b busy=%0b rdy=%0b wo=%0d want 0,0,0,0,1,0",
                  d0_data, d0_dv, d0_last, d0_busy, d0_in_ready, d0_wo);
      end
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < NB + 2; i++) begin
         total++;
         if (d0_last !== 1'b0 || d0_dv !== 1'b0) begin
            bad++;
            $display("FAIL midword_nolast[%0d] got last=%0b dv=%0b want 0,0", i, d0_last, d0_dv);
         end
         @(negedge clk);
      end
      total++;
      if (cnt0 - base !== 3 || d0_in_ready !== 1'b1 || d0_wo !== 4'd0) begin
         bad++;
         $display("FAIL midword_after got cnt=%0d rdy=%0b wo=%0d want 3,1,0", cnt0 - base, d0_in_ready, d0_wo);
      end
      $display("test_reset_midword done");
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      d0_in_data = 8'hFF; d0_in_valid = 1'b1;
      @(negedge clk);
      d0_in_data = 8'h00;
      for (int k = 0; k < 2*NB; k++) begin
         w = (k < NB) ? 8'hFF : 8'h00;
         total++;
         if (d0_dv !== 1'b1 || d0_data !== exp_bit(w, k % NB) || d0_last !== ((k % NB) == NB-1)) begin
            bad++;
            $display("FAIL b2b_bit[%0d] got dv=%0b data=%0b last=%0b want 1,%0b,%0b",
                     k, d0_dv, d0_data, d0_last, exp_bit(w, k % NB), ((k % NB) == NB-1));
         end
         if (k == NB) begin
            total++;
            if (d0_wo !== 4'd8) begin
               bad++;
               $display("FAIL b2b_wo_first got=%0d want=8", d0_wo);
            end
            d0_in_valid = 1'b0;
         end
         @(negedge clk);
      end
      total++;
      if (d0_dv !== 1'b0 || d0_wo !== 4'd0 || d0_busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_done got dv=%0b wo=%0d busy=%0b want 0,0,0", d0_dv, d0_wo, d0_busy);
      end
      $display("test_back_to_back FF,00 done");
   endtask

   task automatic test_gap();
      int base;
      base = cnt2;
      d2_in_data = 8'h0F; d2_in_valid = 1'b1;
      @(negedge clk);
      d2_in_data = 8'h01;
      for (int i = 0; i < NB; i++) begin
         total++;
         if (d2_dv !== 1'b1 || d2_data !== exp_bit(8'h0F, i) || d2_in_ready !== 1'b0
             || d2_last !== (i == NB-1)) begin
            bad++;
            $display("FAIL gap_w0[%0d] got dv=%0b data=%0b rdy=%0b last=%0b want 1,%0b,0,%0b",
                     i, d2_dv, d2_data, d2_in_ready, d2_last, exp_bit(8'h0F, i), (i == NB-1));
         end
         @(negedge clk);
      end
      for (int g = 0; g < 2; g++) begin
         total++;
         if (d2_dv !== 1'b0 || d2_data !== 1'b0 || d2_in_ready !== 1'b0 || d2_busy !== 1'b1
             || d2_wo !== 4'd4) begin
            bad++;
            $display("FAIL gap_idle[%0d] got dv=%0b data=%0b rdy=%0b busy=%0b wo=%0d want 0,0,0,1,4",
                     g, d2_dv, d2_data, d2_in_ready, d2_busy, d2_wo);
         end
         @(negedge clk);
      end
      total++;
      if (d2_in_ready !== 1'b1 || d2_dv !== 1'b0) begin
         bad++;
         $display("FAIL gap_ready got rdy=%0b dv=%0b want 1,0", d2_in_ready, d2_dv);
      end
      @(negedge clk);
      d2_in_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         total++;
         if (d2_dv !== 1'b1 || d2_data !== exp_bit(8'h01, i)) begin
            bad++;
            $display("FAIL gap_w1[%0d] got dv=%0b data=%0b want 1,%0b", i, d2_dv, d2_data, exp_bit(8'h01, i));
         end
         @(negedge clk);
      end
      total++;
      if (d2_wo !== 4'd1 || d2_dv !== 1'b0) begin
         bad++;
         $display("FAIL gap_wo_second got wo=%0d dv=%0b want 1,0", d2_wo, d2_dv);
      end
      total++;
      if (cnt2 - base !== exp_ones(8'h0F) + exp_ones(8'h01)) begin
         bad++;
         $display("FAIL gap_count got=%0d want=%0d", cnt2 - base, exp_ones(8'h0F) + exp_ones(8'h01));
      end
      for (int g = 0; g < 3; g++) @(negedge clk);
      $display("test_gap 0F,01 done");
   endtask

   task automatic test_parity();
      int nvalid = 0;
      d0_in_data = 8'h07; d0_in_valid = 1'b1;
      @(negedge clk);
      d0_in_valid = 1'b0;
      for (int i = 0; i < NB + 2; i++) begin
         if (d0_dv === 1'b1) nvalid++;
         if (i < NB) begin
            total++;
            if (d0_data !== exp_bit(8'h07, i) || d0_last !== (i == NB-1)) begin
               bad++;
               $display("FAIL parity_bit[%0d] got data=%0b last=%0b want %0b,%0b",
                        i, d0_data, d0_last, exp_bit(8'h07, i), (i == NB-1));
            end
         end
         @(negedge clk);
      end
      total++;
      if (nvalid !== NB || d0_wo !== 4'd3) begin
         bad++;
         $display("FAIL parity_done got nvalid=%0d wo=%0d want %0d,3", nvalid, d0_wo, NB);
      end
      $display("test_parity 07 done (NB=%0d)", NB);
   endtask

   initial begin
      test_reset();
      test_single();
      test_reset_midword();
      test_back_to_back();
      test_gap();
      test_parity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
